// File: rtl/wb_host_seq.sv
// Wishbone classic single-beat initiator: one command in, one response out,
// with an ack timeout and a saturating count of timed-out transactions.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// BUS   | strobe/cycle asserted, waiting for ack or timeout
// RESP  | response held until the consumer takes it
module wb_host_seq #(
    parameter int WB_WIDTH  = 32,
    parameter int TIMEOUT   = 16,
    parameter int CNT_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_we,
    input  logic [WB_WIDTH-1:0]  cmd_adr,
    input  logic [WB_WIDTH-1:0]  cmd_dat,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WB_WIDTH-1:0]  rsp_dat,
    output logic                 rsp_err,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic                 wbm_stb_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_we_o,
    output logic [WB_WIDTH-1:0]  wbm_adr_o,
    output logic [WB_WIDTH-1:0]  wbm_dat_o,
    input  logic                 wbm_ack_i,
    input  logic [WB_WIDTH-1:0]  wbm_dat_i
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    // Timer counts down from TIMEOUT-1; terminal count 0 on a strobe cycle aborts.
    localparam logic [CNT_WIDTH-1:0] TMR_LOAD = CNT_WIDTH'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  tmr_q, tmr_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  stb_q, stb_d;
    logic                  we_q, we_d;
    logic [WB_WIDTH-1:0]   adr_q, adr_d;
    logic [WB_WIDTH-1:0]   dat_q, dat_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [WB_WIDTH-1:0]   rsp_dat_q, rsp_dat_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tmr_q       <= '0;
            cmd_ready_q <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            cmd_ready_q <= cmd_ready_d;
            stb_q       <= stb_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        cmd_ready_d = cmd_ready_q;
        stb_d       = stb_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        err_cnt_d   = err_cnt_q;

        case (state_q)
            IDLE: begin
                // cmd_ready comes up on the first edge after reset release
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    we_d        = cmd_we;
                    adr_d       = cmd_adr;
                    dat_d       = cmd_we ? cmd_dat : '0;
                    stb_d       = 1'b1;
                    tmr_d       = TMR_LOAD;
                    cmd_ready_d = 1'b0;
                    state_d     = BUS;
                end
            end
            BUS: begin
                if (wbm_ack_i) begin
                    rsp_dat_d   = we_q ? '0 : wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    stb_d       = 1'b0;
                    we_d        = 1'b0;
                    adr_d       = '0;
                    dat_d       = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (tmr_q == '0) begin
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = '0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    state_d     = RESP;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign err_count = err_cnt_q;
    assign wbm_stb_o = stb_q;
    assign wbm_cyc_o = stb_q;
    assign wbm_we_o  = we_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;

endmodule
